// File: rtl/adma_pkg.sv
// Shared types and constants for the ADMA address-side transfer scheduler.
package adma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPLIT = 2'd1,
    ST_ISSUE = 2'd2
  } sched_state_t;

  localparam int BOUNDARY_4K = 4096;

endpackage

// File: rtl/adma_atx_len_calc.sv
// Combinational burst sizing: beats = min(remaining, MAX_BURST, beats left before the 4 KB page end).
module adma_atx_len_calc
  import adma_pkg::*;
#(
  parameter int DMA_LENGTH_W = 16,
  parameter int DATA_BYTES   = 4,
  parameter int MAX_BURST    = 16
) (
  input  logic [11:0]             addr_lo,
  input  logic [DMA_LENGTH_W-1:0] remaining,
  output logic [8:0]              beats
);

  localparam int BEAT_SHIFT = $clog2(DATA_BYTES);
  localparam int CMP_W      = (DMA_LENGTH_W > 13) ? DMA_LENGTH_W : 13;

  logic [12:0]      room_bytes;
  logic [12:0]      room_beats;
  logic [12:0]      cap;
  logic [CMP_W-1:0] rem_ext;
  logic [CMP_W-1:0] cap_ext;
  logic [CMP_W-1:0] beats_full;

  // Address is beat-aligned, so the page remainder divides exactly into beats.
  assign room_bytes = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
  assign room_beats = room_bytes >> BEAT_SHIFT;
  assign cap        = (room_beats < 13'(MAX_BURST)) ? room_beats : 13'(MAX_BURST);
  assign rem_ext    = CMP_W'(remaining);
  assign cap_ext    = CMP_W'(cap);
  assign beats_full = (rem_ext < cap_ext) ? rem_ext : cap_ext;
  assign beats      = 9'(beats_full);

endmodule

// File: rtl/adma_as_atx_sched.sv
// Splits DMA TX descriptors into AXI bursts (ATXs), bounded by burst size, 4 KB pages and outstanding count.
module adma_as_atx_sched
  import adma_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DMA_LENGTH_W = 16,
  parameter int DATA_BYTES   = 4,
  parameter int MAX_BURST    = 16,
  parameter int MAX_OSTD     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_vld,
  output logic                    tx_rdy,
  input  logic [ADDR_W-1:0]       tx_addr,
  input  logic [DMA_LENGTH_W-1:0] tx_len,
  output logic                    atx_vld,
  input  logic                    atx_rdy,
  output logic [ADDR_W-1:0]       atx_addr,
  output logic [7:0]              atx_len,
  output logic                    atx_last,
  input  logic                    atx_done,
  output logic                    busy
);

  localparam int OSTD_W     = $clog2(MAX_OSTD + 1);
  localparam int BEAT_SHIFT = $clog2(DATA_BYTES);

  sched_state_t            state_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [DMA_LENGTH_W-1:0] remaining_reg;
  logic [8:0]              beats_reg;
  logic [ADDR_W-1:0]       atx_addr_reg;
  logic [7:0]              atx_len_reg;
  logic                    atx_last_reg;
  logic [OSTD_W-1:0]       ostd_cnt_reg;
  logic [OSTD_W-1:0]       ostd_cnt_next;
  logic [8:0]              calc_beats;
  logic                    atx_hs;
  logic                    done_eff;

  adma_atx_len_calc #(
    .DMA_LENGTH_W (DMA_LENGTH_W),
    .DATA_BYTES   (DATA_BYTES),
    .MAX_BURST    (MAX_BURST)
  ) u_len_calc (
    .addr_lo   (addr_reg[11:0]),
    .remaining (remaining_reg),
    .beats     (calc_beats)
  );

  assign atx_hs   = (state_reg == ST_ISSUE) && atx_rdy;
  // A completion with nothing outstanding is spurious and must not underflow the count.
  assign done_eff = atx_done && (ostd_cnt_reg != '0);

  always_comb begin
    ostd_cnt_next = ostd_cnt_reg;
    if (atx_hs && !done_eff) begin
      ostd_cnt_next = ostd_cnt_reg + 1'b1;
    end else if (!atx_hs && done_eff) begin
      ostd_cnt_next = ostd_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      beats_reg     <= '0;
      atx_addr_reg  <= '0;
      atx_len_reg   <= '0;
      atx_last_reg  <= 1'b0;
      ostd_cnt_reg  <= '0;
    end else begin
      ostd_cnt_reg <= ostd_cnt_next;
      case (state_reg)
        ST_IDLE: begin
          if (tx_vld && (tx_len != '0)) begin
            addr_reg      <= tx_addr;
            remaining_reg <= tx_len;
            state_reg     <= ST_SPLIT;
          end
        end
        ST_SPLIT: begin
          // ATX fields are captured only when the burst may go out, then held through ISSUE.
          if (ostd_cnt_reg < OSTD_W'(MAX_OSTD)) begin
            atx_addr_reg <= addr_reg;
            atx_len_reg  <= 8'(calc_beats - 9'd1);
            atx_last_reg <= (remaining_reg == DMA_LENGTH_W'(calc_beats));
            beats_reg    <= calc_beats;
            state_reg    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (atx_rdy) begin
            addr_reg      <= addr_reg + (ADDR_W'(beats_reg) << BEAT_SHIFT);
            remaining_reg <= remaining_reg - DMA_LENGTH_W'(beats_reg);
            state_reg     <= atx_last_reg ? ST_IDLE : ST_SPLIT;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign tx_rdy   = (state_reg == ST_IDLE);
  assign atx_vld  = (state_reg == ST_ISSUE);
  assign busy     = (state_reg != ST_IDLE);
  assign atx_addr = atx_addr_reg;
  assign atx_len  = atx_len_reg;
  assign atx_last = atx_last_reg;

endmodule

// File: tb/tb_adma_as_atx_sched.sv
// Scoreboard bench for adma_as_atx_sched: expected ATXs queued at stimulus time, popped by a monitor.
module tb_adma_as_atx_sched;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
  } atx_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_vld = 1'b0;
  logic        tx_rdy;
  logic [31:0] tx_addr = '0;
  logic [15:0] tx_len = '0;
  logic        atx_vld;
  logic        atx_rdy = 1'b0;
  logic [31:0] atx_addr;
  logic [7:0]  atx_len;
  logic        atx_last;
  logic        atx_done;
  logic        busy;

  logic        done_auto = 1'b0;
  logic        done_manual = 1'b0;
  logic        auto_en = 1'b0;
  int          pend_done = 0;
  int          hs_count = 0;
  int          tests = 0;
  int          fails = 0;
  atx_t        exp_q[$];

  assign atx_done = done_auto | done_manual;

  adma_as_atx_sched #(
    .ADDR_W       (32),
    .DMA_LENGTH_W (16),
    .DATA_BYTES   (4),
    .MAX_BURST    (16),
    .MAX_OSTD     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_vld   (tx_vld),
    .tx_rdy   (tx_rdy),
    .tx_addr  (tx_addr),
    .tx_len   (tx_len),
    .atx_vld  (atx_vld),
    .atx_rdy  (atx_rdy),
    .atx_addr (atx_addr),
    .atx_len  (atx_len),
    .atx_last (atx_last),
    .atx_done (atx_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Prompt completion model: one atx_done pulse the cycle after each handshake.
  always @(posedge clk) begin
    if (rst) pend_done = 0;
    else if (auto_en && atx_vld && atx_rdy) pend_done++;
    #1;
    done_auto = (pend_done > 0);
    if (done_auto) pend_done--;
  end

  // Monitor: every ATX handshake must match the head of the expected queue.
  always @(negedge clk) begin
    atx_t got;
    atx_t e;
    if (!rst && atx_vld && atx_rdy) begin
      hs_count++;
      got = '{addr: atx_addr, len: atx_len, last: atx_last};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL atx_unexpected: got addr=0x%08h len=%0d last=%0d, required none", atx_addr, atx_len, atx_last);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL atx_match: got addr=0x%08h len=%0d last=%0d, required addr=0x%08h len=%0d last=%0d",
                   got.addr, got.len, got.last, e.addr, e.len, e.last);
        end else begin
          $display("[TB] atx addr=0x%08h len=%0d last=%0d ok", got.addr, got.len, got.last);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] l, input logic last);
    exp_q.push_back('{addr: a, len: l, last: last});
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic send_tx(input logic [31:0] a, input logic [15:0] l);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    tx_vld = 1'b1; tx_addr = a; tx_len = l;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_rdy) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 tx_vld = 1'b0;
    check("tx_accept", 64'(ok), 64'd1);
    $display("[TB] tx addr=0x%08h len=%0d accepted=%0d", a, l, ok);
  endtask

  task automatic wait_vld(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (atx_vld) begin ok = 1'b1; break; end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_q_empty(input string name);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 done_manual = 1'b1;
    @(posedge clk); #1 done_manual = 1'b0;
  endtask

  task automatic one_hs(input logic with_done);
    @(posedge clk); #1 atx_rdy = 1'b1; done_manual = with_done;
    @(posedge clk); #1 atx_rdy = 1'b0; done_manual = 1'b0;
  endtask

  initial begin
    int   base;
    logic got;

    // Reset state
    do_reset();
    check("rst_tx_rdy", 64'(tx_rdy), 64'd1);
    check("rst_atx_vld", 64'(atx_vld), 64'd0);
    check("rst_atx_addr", 64'(atx_addr), 64'd0);
    check("rst_atx_len", 64'(atx_len), 64'd0);
    check("rst_atx_last", 64'(atx_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ostd", 64'(dut.ostd_cnt_reg), 64'd0);

    // Three-burst TX with prompt completions
    auto_en = 1'b1; atx_rdy = 1'b1;
    push(32'h1000, 8'd15, 1'b0);
    push(32'h1040, 8'd15, 1'b0);
    push(32'h1080, 8'd7, 1'b1);
    send_tx(32'h1000, 16'd40);
    wait_q_empty("split40_drain");
    repeat (3) @(negedge clk);
    check("split40_busy", 64'(busy), 64'd0);
    check("split40_ostd", 64'(dut.ostd_cnt_reg), 64'd0);

    // 4 KB page crossing
    push(32'h1FF8, 8'd1, 1'b0);
    push(32'h2000, 8'd1, 1'b1);
    send_tx(32'h1FF8, 16'd4);
    wait_q_empty("page4k_drain");

    // Stalled downstream: fields held stable while atx_rdy is low
    atx_rdy = 1'b0;
    push(32'h0300, 8'd2, 1'b1);
    send_tx(32'h0300, 16'd3);
    wait_vld("stall_vld");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_vld_hold", 64'(atx_vld), 64'd1);
      check("stall_addr_hold", 64'(atx_addr), 64'h300);
      check("stall_len_hold", 64'(atx_len), 64'd2);
      check("stall_last_hold", 64'(atx_last), 64'd1);
    end
    @(posedge clk); #1 atx_rdy = 1'b1;
    wait_q_empty("stall_drain");

    // Outstanding limit with no completions
    do_reset();
    auto_en = 1'b0; atx_rdy = 1'b1;
    push(32'h0000, 8'd15, 1'b0);
    push(32'h0040, 8'd15, 1'b0);
    push(32'h0080, 8'd15, 1'b0);
    push(32'h00C0, 8'd15, 1'b1);
    base = hs_count;
    send_tx(32'h0000, 16'd64);
    repeat (12) @(negedge clk);
    check("ostd_limit_hs", 64'(hs_count - base), 64'd2);
    check("ostd_limit_vld", 64'(atx_vld), 64'd0);
    check("ostd_limit_cnt", 64'(dut.ostd_cnt_reg), 64'd2);
    pulse_done();
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (atx_vld) got = 1'b1;
    end
    check("ostd_release_vld", 64'(got), 64'd1);
    pulse_done();
    wait_q_empty("ostd_drain");
    check("ostd_total_hs", 64'(hs_count - base), 64'd4);

    // Simultaneous handshake and completion; completion at zero
    do_reset();
    auto_en = 1'b0; atx_rdy = 1'b0;
    push(32'h0000, 8'd15, 1'b0);
    push(32'h0040, 8'd15, 1'b1);
    send_tx(32'h0000, 16'd32);
    wait_vld("both_first_vld");
    one_hs(1'b0);
    check("both_cnt_one", 64'(dut.ostd_cnt_reg), 64'd1);
    wait_vld("both_second_vld");
    one_hs(1'b1);
    check("both_cnt_stays", 64'(dut.ostd_cnt_reg), 64'd1);
    pulse_done();
    check("done_to_zero", 64'(dut.ostd_cnt_reg), 64'd0);
    pulse_done();
    check("done_at_zero", 64'(dut.ostd_cnt_reg), 64'd0);
    wait_q_empty("both_drain");

    // Reset in ISSUE, then a zero-length descriptor
    atx_rdy = 1'b0;
    send_tx(32'h0500, 16'd4);
    wait_vld("rst_issue_vld");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_atx_vld", 64'(atx_vld), 64'd0);
    check("midrst_tx_rdy", 64'(tx_rdy), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ostd", 64'(dut.ostd_cnt_reg), 64'd0);
    atx_rdy = 1'b1;
    send_tx(32'h0600, 16'd0);
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (atx_vld || busy) got = 1'b1;
    end
    check("len0_no_atx", 64'(got), 64'd0);
    check("len0_tx_rdy", 64'(tx_rdy), 64'd1);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adma_as_atx_sched.md
ADMA_AS_ATX_SCHED -- requirements
Module: adma_as_atx_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning AXI address width.
REQ-002 SHALL have parameter DMA_LENGTH_W, default 16, meaning TX length width in beats.
REQ-003 SHALL have parameter DATA_BYTES, default 4, meaning bytes per beat (power of 2).
REQ-004 SHALL have parameter MAX_BURST, default 16, meaning maximum beats per ATX (power of 2, at most 256).
REQ-005 SHALL have parameter MAX_OSTD, default 2, meaning maximum outstanding ATXs.
REQ-006 SHALL have one clock and a synchronous, active-high reset.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all logic rising-edge.
REQ-008 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-009 SHALL have port tx_vld, input, 1, meaning a TX descriptor is offered.
REQ-010 SHALL have port tx_rdy, output, 1, meaning the scheduler accepts a descriptor.
REQ-011 SHALL have port tx_addr, input, ADDR_W, meaning TX start address, DATA_BYTES-aligned.
REQ-012 SHALL have port tx_len, input, DMA_LENGTH_W, meaning TX length in beats.
REQ-013 SHALL have port atx_vld, output, 1, meaning an ATX request is presented.
REQ-014 SHALL have port atx_rdy, input, 1, meaning the downstream accepts the ATX.
REQ-015 SHALL have port atx_addr, output, ADDR_W, meaning ATX start address.
REQ-016 SHALL have port atx_len, output, 8, meaning AXI LEN (beats-1).
REQ-017 SHALL have port atx_last, output, 1, meaning this is the final ATX of the TX; it drives the TX status tracker start_last input.
REQ-018 SHALL have port atx_done, input, 1, meaning single-cycle pulse per completed ATX.
REQ-019 SHALL have port busy, output, 1, meaning a TX is being split (state is not IDLE).

Function
REQ-020 SHALL implement FSM IDLE/SPLIT/ISSUE; tx_rdy=1 only in IDLE.
REQ-021 SHALL, on tx handshake with tx_len!=0, latch the address and remaining=tx_len, then go to SPLIT.
REQ-022 SHALL, on tx handshake with tx_len==0, stay in IDLE and issue no ATX.
REQ-023 SHALL compute the burst in SPLIT as beats = min(remaining, MAX_BURST, (4096 - addr[11:0])/DATA_BYTES), registering atx_addr, atx_len=beats-1, and atx_last=(remaining==beats).
REQ-024 SHALL move SPLIT->ISSUE only when ostd_cnt<MAX_OSTD, otherwise holding SPLIT.
REQ-025 SHALL assert atx_vld exactly in ISSUE, with atx_addr/atx_len/atx_last stable until the atx_vld&atx_rdy handshake.
REQ-026 SHALL, on ATX handshake, advance addr by beats*DATA_BYTES, subtract beats from remaining, and go to IDLE if atx_last else SPLIT.
REQ-027 SHALL make tx handshake at cycle N give atx_vld at N+2 at the earliest; ATX handshake to next atx_vld is 2 cycles at the earliest.
REQ-028 SHALL keep ostd_cnt: +1 on ATX handshake, -1 on atx_done, unchanged when both occur in the same cycle.
REQ-029 SHALL ignore atx_done while ostd_cnt==0 (no underflow).
REQ-030 SHALL never exceed MAX_OSTD with ostd_cnt.
REQ-031 SHALL allow IDLE to accept a new TX while ATXs of the previous TX are still outstanding.
REQ-032 SHALL ensure no ATX crosses a 4 KB boundary.
REQ-033 SHALL drive all outputs from registers or from the state only.

Reset
REQ-034 SHALL, on rst, go to IDLE with tx_rdy=1, atx_vld=0, atx_addr=0, atx_len=0, atx_last=0, busy=0, ostd_cnt=0, remaining=0.
REQ-035 SHALL, on rst mid-TX, discard the TX and any outstanding count, with no ATX presented on the following cycle.

Structure
REQ-036 SHALL place the state enum and the constant BOUNDARY_4K=4096 in the shared package adma_pkg.
REQ-037 SHALL use the combinational sub-module adma_atx_len_calc to compute the REQ-023 burst length.

Verification (DATA_BYTES=4, MAX_BURST=16, MAX_OSTD=2)
REQ-038 SHALL cover: addr=0x1000, len=40, atx_done prompt -> ATXs (0x1000,15,0), (0x1040,15,0), (0x1080,7,1).
REQ-039 SHALL cover: addr=0x1FF8, len=4 -> ATXs (0x1FF8,1,0), (0x2000,1,1).
REQ-040 SHALL cover: len=64 with atx_done held 0 -> exactly 2 ATXs issued, then atx_vld=0; one atx_done pulse -> third ATX atx_vld within 2 cycles.
REQ-041 SHALL cover: atx_rdy=0 for 5 cycles during ISSUE -> atx_vld=1 with atx_addr/atx_len/atx_last unchanged all 5 cycles.
REQ-042 SHALL cover: ATX handshake and atx_done in the same cycle at ostd_cnt=1 -> ostd_cnt stays 1; atx_done at ostd_cnt=0 -> stays 0.
REQ-043 SHALL cover: rst pulse in ISSUE -> next cycle atx_vld=0, tx_rdy=1, busy=0; len=0 descriptor -> accepted, no atx_vld.
